// File: rtl/cmac_link_monitor_pkg.sv
// Shared definitions for the CMAC link monitor: FSM state encoding,
// counter/timer widths and saturating-increment helpers.
package cmac_link_monitor_pkg;

  typedef enum logic [1:0] {
    S_WAIT_ALIGN  = 2'd0,
    S_LINK_UP     = 2'd1,
    S_RESET_PULSE = 2'd2
  } link_state_e;

  localparam int unsigned LINK_CNT_W  = 32;
  localparam int unsigned RETRY_CNT_W = 16;
  localparam int unsigned TIMER_W     = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LINK_CNT_W-1:0] sat_inc_link(input logic [LINK_CNT_W-1:0] v);
    return (&v) ? v : v + LINK_CNT_W'(1);
  endfunction

  function automatic logic [RETRY_CNT_W-1:0] sat_inc_retry(input logic [RETRY_CNT_W-1:0] v);
    return (&v) ? v : v + RETRY_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, clears both stages
//   d     - asynchronous input
//   q     - synchronized output, 2-cycle latency
module cdc_sync_bit (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/cmac_link_monitor.sv
// Qualifies the raw CMAC stat_rx_aligned flag: synchronizes and debounces
// it, counts link-up/link-down events and issues a GT/CMAC reset request
// pulse when alignment is not reached within the retry window.
// Ports:
//   clk, reset       - core clock, synchronous active-high reset
//   stat_rx_aligned  - raw (asynchronous) alignment flag from CMAC
//   auto_reset_en    - enable reset requests on retry timeout
//   clear_counts     - single-cycle pulse zeroing all event counters
//   rx_aligned_qual  - qualified alignment to cmac_control
//   gt_reset_req     - reset request, RESET_PULSE_CYCLES wide
//   link_up_count    - saturating link-up event count
//   link_down_count  - saturating link-down event count
//   retry_count      - saturating count of issued reset requests
module cmac_link_monitor
  import cmac_link_monitor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = 1024,
  parameter int unsigned RETRY_CYCLES       = 322_000_000,
  parameter int unsigned RESET_PULSE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stat_rx_aligned,
  input  logic                   auto_reset_en,
  input  logic                   clear_counts,
  output logic                   rx_aligned_qual,
  output logic                   gt_reset_req,
  output logic [LINK_CNT_W-1:0]  link_up_count,
  output logic [LINK_CNT_W-1:0]  link_down_count,
  output logic [RETRY_CNT_W-1:0] retry_count
);

  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PULSE_W = $clog2(RESET_PULSE_CYCLES + 1);

  localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RETRY_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESET_PULSE_CYCLES - 1);

  logic               aligned_s;
  link_state_e        state_q, state_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic               up_evt, down_evt, retry_evt;

  // Raw flag crosses in from the CMAC clock domain.
  cdc_sync_bit u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (stat_rx_aligned),
    .q     (aligned_s)
  );

  // Next-state, timers and event strobes.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pulse_d   = '0;
    up_evt    = 1'b0;
    down_evt  = 1'b0;
    retry_evt = 1'b0;

    // Debounce is held at 0 during the reset pulse so a stale run cannot
    // immediately re-qualify the link once the pulse ends.
    if (state_q == S_RESET_PULSE || !aligned_s) begin
      deb_d = '0;
    end else if (deb_q != DEB_MAX) begin
      deb_d = deb_q + DEB_W'(1);
    end else begin
      deb_d = deb_q;
    end

    case (state_q)
      S_WAIT_ALIGN: begin
        // Link-up takes priority over a coincident retry timeout.
        if (deb_q == DEB_MAX) begin
          state_d = S_LINK_UP;
          timer_d = '0;
          up_evt  = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (auto_reset_en) begin
            state_d   = S_RESET_PULSE;
            retry_evt = 1'b1;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_LINK_UP: begin
        timer_d = '0;
        if (!aligned_s) begin
          state_d  = S_WAIT_ALIGN;
          down_evt = 1'b1;
        end
      end
      S_RESET_PULSE: begin
        timer_d = '0;
        if (pulse_q == PULSE_LAST) begin
          state_d = S_WAIT_ALIGN;
        end else begin
          pulse_d = pulse_q + PULSE_W'(1);
        end
      end
      default: begin
        state_d = S_WAIT_ALIGN;
        timer_d = '0;
      end
    endcase
  end

  // State register; outputs decoded from next state so they are flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_WAIT_ALIGN;
      deb_q           <= '0;
      timer_q         <= '0;
      pulse_q         <= '0;
      rx_aligned_qual <= 1'b0;
      gt_reset_req    <= 1'b0;
    end else begin
      state_q         <= state_d;
      deb_q           <= deb_d;
      timer_q         <= timer_d;
      pulse_q         <= pulse_d;
      rx_aligned_qual <= (state_d == S_LINK_UP);
      gt_reset_req    <= (state_d == S_RESET_PULSE);
    end
  end

  // Event counters; a clear drops any same-cycle event.
  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      link_up_count <= '0;
    end else if (up_evt) begin
      link_up_count <= sat_inc_link(link_up_count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      link_down_count <= '0;
    end else if (down_evt) begin
      link_down_count <= sat_inc_link(link_down_count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      retry_count <= '0;
    end else if (retry_evt) begin
      retry_count <= sat_inc_retry(retry_count);
    end
  end

endmodule

// File: tb/tb_cmac_link_monitor.sv
// Testbench for cmac_link_monitor: directed scenarios checked against a
// table of expected values, plus randomized stimulus compared every cycle
// against a behavioural reference model.
module tb_cmac_link_monitor;

  localparam int DEB   = 8;
  localparam int RETRY = 100;
  localparam int PULSE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        raw;
  logic        auto_en;
  logic        clr;
  logic        qual;
  logic        req;
  logic [31:0] up_cnt;
  logic [31:0] down_cnt;
  logic [15:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmac_link_monitor #(
    .DEBOUNCE_CYCLES    (DEB),
    .RETRY_CYCLES       (RETRY),
    .RESET_PULSE_CYCLES (PULSE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stat_rx_aligned (raw),
    .auto_reset_en   (auto_en),
    .clear_counts    (clr),
    .rx_aligned_qual (qual),
    .gt_reset_req    (req),
    .link_up_count   (up_cnt),
    .link_down_count (down_cnt),
    .retry_count     (retry_cnt)
  );

  // ---------------- reference model ----------------
  // Mode: 0 waiting for alignment, 1 link up, 2 issuing reset request.
  bit          raw_hist[$];
  int          m_mode, m_run, m_timer, m_left;
  bit          m_qual, m_req;
  logic [31:0] m_up, m_down;
  logic [15:0] m_retry;

  task automatic model_step(input bit r, input bit a, input bit c, input bit rs);
    bit          as;
    int          nm;
    logic [31:0] nu, nd;
    logic [15:0] nr;
    if (rs) begin
      raw_hist.delete();
      m_mode = 0; m_run = 0; m_timer = 0; m_left = 0;
      m_qual = 0; m_req = 0; m_up = 0; m_down = 0; m_retry = 0;
      return;
    end
    // Synchronized view = raw value sampled two edges ago.
    as = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
    nm = m_mode; nu = m_up; nd = m_down; nr = m_retry;
    case (m_mode)
      0: begin
        if (m_run >= DEB) begin
          nm = 1; m_timer = 0;
          nu = (m_up == 32'hFFFF_FFFF) ? m_up : m_up + 1;
        end else if (m_timer == RETRY - 1) begin
          m_timer = 0;
          if (a) begin
            nm = 2; m_left = PULSE;
            nr = (m_retry == 16'hFFFF) ? m_retry : m_retry + 1;
          end
        end else begin
          m_timer++;
        end
      end
      1: if (!as) begin
        nm = 0; m_timer = 0;
        nd = (m_down == 32'hFFFF_FFFF) ? m_down : m_down + 1;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin nm = 0; m_timer = 0; end
      end
    endcase
    if (m_mode == 2 || !as) m_run = 0;
    else if (m_run < DEB) m_run++;
    raw_hist.push_back(r);
    if (raw_hist.size() > 4) void'(raw_hist.pop_front());
    m_mode = nm;
    m_qual = (nm == 1);
    m_req  = (nm == 2);
    if (c) begin m_up = 0; m_down = 0; m_retry = 0; end
    else   begin m_up = nu; m_down = nd; m_retry = nr; end
  endtask

  // ---------------- expected-value table ----------------
  typedef struct {
    int          scen;
    int          cyc;
    logic        qual;
    logic        req;
    logic [31:0] up;
    logic [31:0] down;
    logic [15:0] retry;
  } vec_t;

  vec_t vecs[$];

  // Apply inputs for one cycle, advance the model, then land on the negedge.
  task automatic do_cycle(input bit r, input bit a, input bit c, input bit rs);
    raw = r; auto_en = a; clr = c; reset = rs;
    model_step(r, a, c, rs);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag, input int cyc);
    checks++;
    if (qual !== m_qual || req !== m_req || up_cnt !== m_up ||
        down_cnt !== m_down || retry_cnt !== m_retry) begin
      errors++;
      $display("FAIL model %s cyc %0d: got q=%b r=%b up=%0h dn=%0h rt=%0h want q=%b r=%b up=%0h dn=%0h rt=%0h",
               tag, cyc, qual, req, up_cnt, down_cnt, retry_cnt,
               m_qual, m_req, m_up, m_down, m_retry);
    end
  endtask

  task automatic check_table(input int s, input int cyc);
    foreach (vecs[i]) begin
      if (vecs[i].scen == s && vecs[i].cyc == cyc) begin
        checks++;
        if (qual !== vecs[i].qual || req !== vecs[i].req || up_cnt !== vecs[i].up ||
            down_cnt !== vecs[i].down || retry_cnt !== vecs[i].retry) begin
          errors++;
          $display("FAIL vec s%0d c%0d: got q=%b r=%b up=%0h dn=%0h rt=%0h want q=%b r=%b up=%0h dn=%0h rt=%0h",
                   s, cyc, qual, req, up_cnt, down_cnt, retry_cnt,
                   vecs[i].qual, vecs[i].req, vecs[i].up, vecs[i].down, vecs[i].retry);
        end
      end
    end
  endtask

  task automatic stim(input int s, input int c, output bit r, output bit a,
                      output bit cl, output bit rs);
    r = 1'b0; a = 1'b0; cl = 1'b0; rs = 1'b0;
    case (s)
      0: r = (c != 15);                          // link up, one-cycle drop
      1: r = ((c % 8) != 7);                     // 7 high / 1 low, never qualifies
      2: begin a = 1'b1; rs = (c == 309); end    // retry pulses, reset mid-pulse
      3: ;                                       // no auto reset
      default: begin                             // clear + saturation
        r  = !(c == 15 || c == 30);
        cl = (c == 17);
      end
    endcase
  endtask

  task automatic run_scen(input int s, input int ncyc);
    bit r, a, cl, rs;
    do_cycle(0, 0, 0, 1);
    do_cycle(0, 0, 0, 1);
    for (int c = 0; c <= ncyc; c++) begin
      check_table(s, c);
      check_model($sformatf("s%0d", s), c);
      if (s == 4 && c == 31) begin
        force dut.link_down_count = 32'hFFFF_FFFF;
        #1;
        release dut.link_down_count;
        m_down = 32'hFFFF_FFFF;
      end
      stim(s, c, r, a, cl, rs);
      do_cycle(r, a, cl, rs);
    end
  endtask

  int scen_len[5] = '{30, 200, 312, 500, 36};

  initial begin
    bit r, a, cl, rs;
    int run_left;
    bit lvl;

    raw = 0; auto_en = 0; clr = 0; reset = 1;
    @(negedge clk);

    vecs = '{
      '{0,  0, 0, 0, 0, 0, 0},
      '{0, 10, 0, 0, 0, 0, 0},
      '{0, 11, 1, 0, 1, 0, 0},
      '{0, 17, 1, 0, 1, 0, 0},
      '{0, 18, 0, 0, 1, 1, 0},
      '{0, 26, 0, 0, 1, 1, 0},
      '{0, 27, 1, 0, 2, 1, 0},
      '{1, 200, 0, 0, 0, 0, 0},
      '{2,  99, 0, 0, 0, 0, 0},
      '{2, 100, 0, 1, 0, 0, 1},
      '{2, 103, 0, 1, 0, 0, 1},
      '{2, 104, 0, 0, 0, 0, 1},
      '{2, 203, 0, 0, 0, 0, 1},
      '{2, 204, 0, 1, 0, 0, 2},
      '{2, 207, 0, 1, 0, 0, 2},
      '{2, 208, 0, 0, 0, 0, 2},
      '{2, 309, 0, 1, 0, 0, 3},
      '{2, 310, 0, 0, 0, 0, 0},
      '{3, 500, 0, 0, 0, 0, 0},
      '{4, 11, 1, 0, 1, 0, 0},
      '{4, 18, 0, 0, 0, 0, 0},
      '{4, 27, 1, 0, 1, 0, 0},
      '{4, 32, 1, 0, 1, 32'hFFFF_FFFF, 0},
      '{4, 33, 0, 0, 1, 32'hFFFF_FFFF, 0}
    };

    for (int s = 0; s < 5; s++) run_scen(s, scen_len[s]);

    // Randomized runs of high/low levels with occasional clear and reset.
    do_cycle(0, 0, 0, 1);
    run_left = 0; lvl = 0; a = 1;
    for (int c = 0; c < 4000; c++) begin
      check_model("rand", c);
      if (run_left == 0) begin
        lvl = ~lvl;
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : $urandom_range(1, 12);
      end
      run_left--;
      if ((c % 400) == 0) a = $urandom_range(0, 1);
      cl = ($urandom_range(0, 99) == 0);
      rs = ($urandom_range(0, 999) == 0);
      do_cycle(lvl, a, cl, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
